// File: rtl/id_fwd_pkg.sv
// id_fwd_pkg: shared decode definitions for the ID stage.
// Holds MIPS32 opcode/funct encodings, the aluop/alusel codes passed to EX,
// the branch/move classification used inside ID, and a few well-known constants.
package id_fwd_pkg;

   localparam logic [31:0] ZeroWord   = 32'h0000_0000;
   localparam logic [4:0]  NOPRegAddr = 5'b00000;
   localparam logic [4:0]  LinkRegAddr = 5'd31;

   // primary opcodes
   localparam logic [5:0] OP_SPECIAL  = 6'b000000;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OP_J        = 6'b000010;
   localparam logic [5:0] OP_JAL      = 6'b000011;
   localparam logic [5:0] OP_BEQ      = 6'b000100;
   localparam logic [5:0] OP_BNE      = 6'b000101;
   localparam logic [5:0] OP_ADDIU    = 6'b001001;
   localparam logic [5:0] OP_SLTI     = 6'b001010;
   localparam logic [5:0] OP_SLTIU    = 6'b001011;
   localparam logic [5:0] OP_ANDI     = 6'b001100;
   localparam logic [5:0] OP_ORI      = 6'b001101;
   localparam logic [5:0] OP_XORI     = 6'b001110;
   localparam logic [5:0] OP_LUI      = 6'b001111;
   localparam logic [5:0] OP_LW       = 6'b100011;
   localparam logic [5:0] OP_SW       = 6'b101011;

   // SPECIAL funct codes
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_MOVZ = 6'b001010;
   localparam logic [5:0] FN_MOVN = 6'b001011;
   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MTHI = 6'b010001;
   localparam logic [5:0] FN_MFLO = 6'b010010;
   localparam logic [5:0] FN_MTLO = 6'b010011;
   localparam logic [5:0] FN_MULT = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   // SPECIAL2 funct codes
   localparam logic [5:0] FN2_MUL = 6'b000010;
   localparam logic [5:0] FN2_CLZ = 6'b100000;
   localparam logic [5:0] FN2_CLO = 6'b100001;

   // aluop codes
   localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
   localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
   localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
   localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
   localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
   localparam logic [7:0] EXE_LUI_OP   = 8'b01011100;
   localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
   localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
   localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
   localparam logic [7:0] EXE_MOVZ_OP  = 8'b00001010;
   localparam logic [7:0] EXE_MOVN_OP  = 8'b00001011;
   localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
   localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
   localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
   localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
   localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
   localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
   localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
   localparam logic [7:0] EXE_ADD_OP   = 8'b00100000;
   localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
   localparam logic [7:0] EXE_SUB_OP   = 8'b00100010;
   localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
   localparam logic [7:0] EXE_CLZ_OP   = 8'b10110000;
   localparam logic [7:0] EXE_CLO_OP   = 8'b10110001;
   localparam logic [7:0] EXE_MUL_OP   = 8'b10101001;
   localparam logic [7:0] EXE_J_OP     = 8'b01001111;
   localparam logic [7:0] EXE_JAL_OP   = 8'b01010000;
   localparam logic [7:0] EXE_JR_OP    = 8'b00001000;
   localparam logic [7:0] EXE_BEQ_OP   = 8'b01010001;
   localparam logic [7:0] EXE_BNE_OP   = 8'b01010010;
   localparam logic [7:0] EXE_LW_OP    = 8'b11100011;
   localparam logic [7:0] EXE_SW_OP    = 8'b11101011;

   // alusel codes
   localparam logic [2:0] SEL_NOP    = 3'b000;
   localparam logic [2:0] SEL_LOGIC  = 3'b001;
   localparam logic [2:0] SEL_SHIFT  = 3'b010;
   localparam logic [2:0] SEL_MOVE   = 3'b011;
   localparam logic [2:0] SEL_ARITH  = 3'b100;
   localparam logic [2:0] SEL_MUL    = 3'b101;
   localparam logic [2:0] SEL_JB     = 3'b110;
   localparam logic [2:0] SEL_LDST   = 3'b111;

   typedef enum logic [2:0] {BR_NONE, BR_J, BR_JR, BR_BEQ, BR_BNE} br_kind_e;
   typedef enum logic [1:0] {MV_NONE, MV_N, MV_Z} mv_kind_e;

endpackage

// File: rtl/id_fwd_stage_mux.sv
// id_fwd_mux: priority forwarding mux for one ID operand.
// Ports: addr_i (register read address), rf_data_i (regfile data),
//        fwd_wreg_i/fwd_wd_i/fwd_wdata_i (packed forwarding slots, slot 0 in
//        the low bits and youngest), data_o (resolved operand value).
module id_fwd_mux
   import id_fwd_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5,
   parameter int FWD_N  = 2
) (
   input  logic [RA_W-1:0]         addr_i,
   input  logic [DATA_W-1:0]       rf_data_i,
   input  logic [FWD_N-1:0]        fwd_wreg_i,
   input  logic [FWD_N*RA_W-1:0]   fwd_wd_i,
   input  logic [FWD_N*DATA_W-1:0] fwd_wdata_i,
   output logic [DATA_W-1:0]       data_o
);

   always_comb begin
      data_o = rf_data_i;
      // Walk oldest to youngest so the lowest matching index is applied last.
      for (int i = FWD_N - 1; i >= 0; i--) begin
         if (fwd_wreg_i[i] && (fwd_wd_i[i*RA_W +: RA_W] == addr_i))
            data_o = fwd_wdata_i[i*DATA_W +: DATA_W];
      end
      // $0 is hardwired to zero regardless of what a slot claims to write.
      if (addr_i == '0)
         data_o = DATA_W'(ZeroWord);
   end

endmodule

// File: rtl/id_fwd_stage.sv
// id_fwd_stage: MIPS32 decode stage merged with the ID/EX pipeline register.
// Inputs: clk, rst, ctrl stall/flush, pc/instruction from IF/ID, regfile data,
//         forwarding slots (0 = EX, youngest), ex_is_load_i.
// Outputs: combinational regfile read enables/addresses, load-use stall request,
//          branch flag/target; registered ex_* bundle for EX; in_delayslot_o.
module id_fwd_stage
   import id_fwd_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5,
   parameter int FWD_N  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall_id_i,
   input  logic                    stall_ex_i,
   input  logic                    flush_i,
   input  logic [DATA_W-1:0]       pc_i,
   input  logic [31:0]             inst_i,
   input  logic [DATA_W-1:0]       reg1_data_i,
   input  logic [DATA_W-1:0]       reg2_data_i,
   output logic                    reg1_read_o,
   output logic                    reg2_read_o,
   output logic [RA_W-1:0]         reg1_addr_o,
   output logic [RA_W-1:0]         reg2_addr_o,
   input  logic [FWD_N-1:0]        fwd_wreg_i,
   input  logic [FWD_N*RA_W-1:0]   fwd_wd_i,
   input  logic [FWD_N*DATA_W-1:0] fwd_wdata_i,
   input  logic                    ex_is_load_i,
   output logic                    stallreq_o,
   output logic                    branch_flag_o,
   output logic [DATA_W-1:0]       branch_target_o,
   output logic [7:0]              ex_aluop_o,
   output logic [2:0]              ex_alusel_o,
   output logic [DATA_W-1:0]       ex_reg1_o,
   output logic [DATA_W-1:0]       ex_reg2_o,
   output logic [RA_W-1:0]         ex_wd_o,
   output logic                    ex_wreg_o,
   output logic [DATA_W-1:0]       ex_link_addr_o,
   output logic                    ex_in_delayslot_o,
   output logic [31:0]             ex_inst_o,
   output logic                    in_delayslot_o
);

   logic [5:0]        op, funct;
   logic [RA_W-1:0]   rs, rt, rd;
   logic [DATA_W-1:0] pc_plus4, fwd1, fwd2, op1, op2, imm;
   logic [7:0]        aluop_d;
   logic [2:0]        alusel_d;
   logic [RA_W-1:0]   wd_d;
   logic              wreg_dec, wreg_d, read1, read2, br_taken;
   logic [DATA_W-1:0] link_d, target_d;
   br_kind_e          br_kind;
   mv_kind_e          mv_kind;

   logic [7:0]        ex_aluop_q;
   logic [2:0]        ex_alusel_q;
   logic [DATA_W-1:0] ex_reg1_q, ex_reg2_q, ex_link_q;
   logic [RA_W-1:0]   ex_wd_q;
   logic              ex_wreg_q, ex_ds_q, ds_q;
   logic [31:0]       ex_inst_q;

   assign op       = inst_i[31:26];
   assign funct    = inst_i[5:0];
   assign rs       = inst_i[21+:RA_W];
   assign rt       = inst_i[16+:RA_W];
   assign rd       = inst_i[11+:RA_W];
   assign pc_plus4 = pc_i + DATA_W'(4);

   // Operand-independent decode: read enables, immediate, op codes, destination.
   always_comb begin
      aluop_d  = EXE_NOP_OP;
      alusel_d = SEL_NOP;
      wd_d     = rd;
      wreg_dec = 1'b0;
      read1    = 1'b0;
      read2    = 1'b0;
      imm      = '0;
      link_d   = '0;
      br_kind  = BR_NONE;
      mv_kind  = MV_NONE;
      unique case (op)
         OP_SPECIAL: begin
            read1 = 1'b1;
            read2 = 1'b1;
            unique case (funct)
               FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                  wreg_dec = 1'b1; alusel_d = SEL_LOGIC;
                  aluop_d  = (funct == FN_AND) ? EXE_AND_OP : (funct == FN_OR) ? EXE_OR_OP :
                             (funct == FN_XOR) ? EXE_XOR_OP : EXE_NOR_OP;
               end
               FN_SLLV, FN_SRLV, FN_SRAV: begin
                  wreg_dec = 1'b1; alusel_d = SEL_SHIFT;
                  aluop_d  = (funct == FN_SLLV) ? EXE_SLL_OP : (funct == FN_SRLV) ? EXE_SRL_OP : EXE_SRA_OP;
               end
               // Shift-by-immediate: shamt rides in the operand-1 slot as an immediate.
               FN_SLL, FN_SRL, FN_SRA: begin
                  wreg_dec = 1'b1; alusel_d = SEL_SHIFT; read1 = 1'b0;
                  imm      = DATA_W'(inst_i[10:6]);
                  aluop_d  = (funct == FN_SLL) ? EXE_SLL_OP : (funct == FN_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
               end
               FN_MFHI, FN_MFLO: begin
                  wreg_dec = 1'b1; alusel_d = SEL_MOVE; read1 = 1'b0; read2 = 1'b0;
                  aluop_d  = (funct == FN_MFHI) ? EXE_MFHI_OP : EXE_MFLO_OP;
               end
               FN_MTHI, FN_MTLO: begin
                  read2   = 1'b0;
                  aluop_d = (funct == FN_MTHI) ? EXE_MTHI_OP : EXE_MTLO_OP;
               end
               FN_MOVN, FN_MOVZ: begin
                  alusel_d = SEL_MOVE;
                  aluop_d  = (funct == FN_MOVN) ? EXE_MOVN_OP : EXE_MOVZ_OP;
                  mv_kind  = (funct == FN_MOVN) ? MV_N : MV_Z;
               end
               FN_SLT, FN_SLTU, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU: begin
                  wreg_dec = 1'b1; alusel_d = SEL_ARITH;
                  aluop_d  = {2'b00, funct};
               end
               FN_MULT, FN_MULTU: aluop_d = (funct == FN_MULT) ? EXE_MULT_OP : EXE_MULTU_OP;
               FN_JR: begin
                  read2 = 1'b0; alusel_d = SEL_JB; aluop_d = EXE_JR_OP; br_kind = BR_JR;
               end
               default: begin
                  read1 = 1'b0; read2 = 1'b0;
               end
            endcase
         end
         OP_SPECIAL2: begin
            read1 = 1'b1; wreg_dec = 1'b1;
            unique case (funct)
               FN2_CLZ: begin alusel_d = SEL_ARITH; aluop_d = EXE_CLZ_OP; end
               FN2_CLO: begin alusel_d = SEL_ARITH; aluop_d = EXE_CLO_OP; end
               FN2_MUL: begin alusel_d = SEL_MUL; aluop_d = EXE_MUL_OP; read2 = 1'b1; end
               default: begin read1 = 1'b0; wreg_dec = 1'b0; end
            endcase
         end
         OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
            read1 = 1'b1; wreg_dec = 1'b1; wd_d = rt; alusel_d = SEL_LOGIC;
            imm   = (op == OP_LUI) ? DATA_W'({inst_i[15:0], 16'h0000}) : DATA_W'(inst_i[15:0]);
            // LUI is an OR against $0 with the pre-shifted immediate.
            aluop_d = (op == OP_ANDI) ? EXE_AND_OP : (op == OP_XORI) ? EXE_XOR_OP : EXE_OR_OP;
         end
         OP_SLTI, OP_SLTIU, OP_ADDIU: begin
            read1 = 1'b1; wreg_dec = 1'b1; wd_d = rt; alusel_d = SEL_ARITH;
            imm   = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};
            aluop_d = (op == OP_SLTI) ? EXE_SLT_OP : (op == OP_SLTIU) ? EXE_SLTU_OP : EXE_ADDU_OP;
         end
         OP_J: begin
            alusel_d = SEL_JB; aluop_d = EXE_J_OP; br_kind = BR_J;
         end
         OP_JAL: begin
            alusel_d = SEL_JB; aluop_d = EXE_JAL_OP; br_kind = BR_J;
            wreg_dec = 1'b1; wd_d = RA_W'(LinkRegAddr); link_d = pc_i + DATA_W'(8);
         end
         OP_BEQ, OP_BNE: begin
            read1 = 1'b1; read2 = 1'b1; alusel_d = SEL_JB;
            aluop_d = (op == OP_BEQ) ? EXE_BEQ_OP : EXE_BNE_OP;
            br_kind = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
         end
         OP_LW: begin
            read1 = 1'b1; wreg_dec = 1'b1; wd_d = rt; alusel_d = SEL_LDST; aluop_d = EXE_LW_OP;
         end
         OP_SW: begin
            read1 = 1'b1; read2 = 1'b1; alusel_d = SEL_LDST; aluop_d = EXE_SW_OP;
         end
         default: ;
      endcase
   end

   id_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W), .FWD_N(FWD_N)) u_mux1 (
      .addr_i(rs), .rf_data_i(reg1_data_i), .fwd_wreg_i(fwd_wreg_i),
      .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .data_o(fwd1));
   id_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W), .FWD_N(FWD_N)) u_mux2 (
      .addr_i(rt), .rf_data_i(reg2_data_i), .fwd_wreg_i(fwd_wreg_i),
      .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .data_o(fwd2));

   assign op1 = read1 ? fwd1 : imm;
   assign op2 = read2 ? fwd2 : imm;

   // Operand-dependent decode: branch resolution and conditional-move write enable.
   always_comb begin
      br_taken = 1'b0;
      target_d = '0;
      wreg_d   = wreg_dec;
      unique case (br_kind)
         BR_J:    begin br_taken = 1'b1; target_d = {pc_plus4[DATA_W-1:28], inst_i[25:0], 2'b00}; end
         BR_JR:   begin br_taken = 1'b1; target_d = op1; end
         BR_BEQ, BR_BNE: begin
            br_taken = (br_kind == BR_BEQ) ? (op1 == op2) : (op1 != op2);
            target_d = pc_plus4 + {{(DATA_W-18){inst_i[15]}}, inst_i[15:0], 2'b00};
         end
         default: ;
      endcase
      unique case (mv_kind)
         MV_N:    wreg_d = (op2 != '0);
         MV_Z:    wreg_d = (op2 == '0);
         default: ;
      endcase
   end

   // Load-use: only slot 0 (EX) can still be an unresolved load result.
   assign stallreq_o = ex_is_load_i && fwd_wreg_i[0] && (fwd_wd_i[RA_W-1:0] != '0) &&
                       ((read1 && (rs == fwd_wd_i[RA_W-1:0])) ||
                        (read2 && (rt == fwd_wd_i[RA_W-1:0])));

   assign branch_flag_o   = br_taken && !stallreq_o;
   assign branch_target_o = target_d;
   assign reg1_read_o     = read1;
   assign reg2_read_o     = read2;
   assign reg1_addr_o     = rs;
   assign reg2_addr_o     = rt;
   assign in_delayslot_o  = ds_q;

   // ID/EX register: flush and ID-only stall both insert a NOP bubble.
   always_ff @(posedge clk) begin
      if (rst || flush_i || (stall_id_i && !stall_ex_i)) begin
         ex_aluop_q  <= EXE_NOP_OP;
         ex_alusel_q <= SEL_NOP;
         ex_reg1_q   <= '0;
         ex_reg2_q   <= '0;
         ex_wd_q     <= RA_W'(NOPRegAddr);
         ex_wreg_q   <= 1'b0;
         ex_link_q   <= '0;
         ex_ds_q     <= 1'b0;
         ex_inst_q   <= '0;
      end else if (!stall_id_i) begin
         ex_aluop_q  <= aluop_d;
         ex_alusel_q <= alusel_d;
         ex_reg1_q   <= op1;
         ex_reg2_q   <= op2;
         ex_wd_q     <= wd_d;
         ex_wreg_q   <= wreg_d;
         ex_link_q   <= link_d;
         ex_ds_q     <= ds_q;
         ex_inst_q   <= inst_i;
      end
   end

   // The instruction after a taken branch/jump is its delay slot.
   always_ff @(posedge clk) begin
      if (rst || flush_i)
         ds_q <= 1'b0;
      else if (!stall_id_i)
         ds_q <= branch_flag_o;
   end

   assign ex_aluop_o        = ex_aluop_q;
   assign ex_alusel_o       = ex_alusel_q;
   assign ex_reg1_o         = ex_reg1_q;
   assign ex_reg2_o         = ex_reg2_q;
   assign ex_wd_o           = ex_wd_q;
   assign ex_wreg_o         = ex_wreg_q;
   assign ex_link_addr_o    = ex_link_q;
   assign ex_in_delayslot_o = ex_ds_q;
   assign ex_inst_o         = ex_inst_q;

endmodule

// File: tb/tb_id_fwd_stage.sv
module tb_id_fwd_stage;

   localparam int DATA_W = 32;
   localparam int RA_W   = 5;
   localparam int FWD_N  = 2;

   logic                    clk = 1'b0;
   logic                    rst, stall_id_i, stall_ex_i, flush_i;
   logic [DATA_W-1:0]       pc_i;
   logic [31:0]             inst_i;
   logic [DATA_W-1:0]       reg1_data_i, reg2_data_i;
   logic                    reg1_read_o, reg2_read_o;
   logic [RA_W-1:0]         reg1_addr_o, reg2_addr_o;
   logic [FWD_N-1:0]        fwd_wreg_i;
   logic [FWD_N*RA_W-1:0]   fwd_wd_i;
   logic [FWD_N*DATA_W-1:0] fwd_wdata_i;
   logic                    ex_is_load_i;
   logic                    stallreq_o, branch_flag_o;
   logic [DATA_W-1:0]       branch_target_o;
   logic [7:0]              ex_aluop_o;
   logic [2:0]              ex_alusel_o;
   logic [DATA_W-1:0]       ex_reg1_o, ex_reg2_o, ex_link_addr_o;
   logic [RA_W-1:0]         ex_wd_o;
   logic                    ex_wreg_o, ex_in_delayslot_o, in_delayslot_o;
   logic [31:0]             ex_inst_o;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   id_fwd_stage #(.DATA_W(DATA_W), .RA_W(RA_W), .FWD_N(FWD_N)) dut (
      .clk(clk), .rst(rst), .stall_id_i(stall_id_i), .stall_ex_i(stall_ex_i),
      .flush_i(flush_i), .pc_i(pc_i), .inst_i(inst_i),
      .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
      .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
      .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
      .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
      .ex_is_load_i(ex_is_load_i), .stallreq_o(stallreq_o),
      .branch_flag_o(branch_flag_o), .branch_target_o(branch_target_o),
      .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
      .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o),
      .ex_wreg_o(ex_wreg_o), .ex_link_addr_o(ex_link_addr_o),
      .ex_in_delayslot_o(ex_in_delayslot_o), .ex_inst_o(ex_inst_o),
      .in_delayslot_o(in_delayslot_o));

   task automatic set_idle();
      stall_id_i = 0; stall_ex_i = 0; flush_i = 0; pc_i = '0; inst_i = '0;
      reg1_data_i = '0; reg2_data_i = '0; fwd_wreg_i = '0; fwd_wd_i = '0;
      fwd_wdata_i = '0; ex_is_load_i = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      set_idle(); rst = 1; tick(); rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      inst_i = 32'h3401_1100;          // ORI $1,$0,0x1100
      tick();
      rst = 1; tick(); rst = 0;
      vectors++; if (ex_wreg_o !== 1'b0) begin miscompares++; $display("FAIL rst_wreg got %0h exp 0", ex_wreg_o); end
      vectors++; if (ex_reg2_o !== 32'h0) begin miscompares++; $display("FAIL rst_reg2 got %h exp 0", ex_reg2_o); end
      vectors++; if (ex_aluop_o !== 8'h00 || ex_wd_o !== 5'd0) begin miscompares++; $display("FAIL rst_op got %h/%0d exp 0/0", ex_aluop_o, ex_wd_o); end
      vectors++; if (in_delayslot_o !== 1'b0) begin miscompares++; $display("FAIL rst_ds got %0b exp 0", in_delayslot_o); end
   endtask

   task automatic test_ori();
      do_reset();
      inst_i = 32'h3401_1100;
      #1;
      vectors++; if (reg1_read_o !== 1'b1 || reg2_read_o !== 1'b0) begin miscompares++; $display("FAIL ori_read got %0b%0b exp 10", reg1_read_o, reg2_read_o); end
      tick();
      vectors++; if (ex_reg1_o !== 32'h0) begin miscompares++; $display("FAIL ori_reg1 got %h exp 0", ex_reg1_o); end
      vectors++; if (ex_reg2_o !== 32'h0000_1100) begin miscompares++; $display("FAIL ori_reg2 got %h exp 00001100", ex_reg2_o); end
      vectors++; if (ex_wd_o !== 5'd1 || ex_wreg_o !== 1'b1) begin miscompares++; $display("FAIL ori_wd got %0d/%0b exp 1/1", ex_wd_o, ex_wreg_o); end
      vectors++; if (ex_aluop_o !== 8'h25 || ex_alusel_o !== 3'b001) begin miscompares++; $display("FAIL ori_op got %h/%0d exp 25/1", ex_aluop_o, ex_alusel_o); end
   endtask

   task automatic test_fwd_priority();
      do_reset();
      inst_i = 32'h0022_1825;          // OR $3,$1,$2
      reg1_data_i = 32'h1111; reg2_data_i = 32'h1234;
      fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_wdata_i = {32'h5555, 32'hAAAA};
      tick();
      vectors++; if (ex_reg1_o !== 32'hAAAA) begin miscompares++; $display("FAIL fwd_young got %h exp 0000aaaa", ex_reg1_o); end
      vectors++; if (ex_reg2_o !== 32'h1234 || ex_wd_o !== 5'd3) begin miscompares++; $display("FAIL fwd_rf got %h/%0d exp 00001234/3", ex_reg2_o, ex_wd_o); end
      fwd_wreg_i = 2'b10;
      tick();
      vectors++; if (ex_reg1_o !== 32'h5555) begin miscompares++; $display("FAIL fwd_old got %h exp 00005555", ex_reg1_o); end
      fwd_wreg_i = 2'b00;
      tick();
      vectors++; if (ex_reg1_o !== 32'h1111) begin miscompares++; $display("FAIL fwd_none got %h exp 00001111", ex_reg1_o); end
   endtask

   task automatic test_zero_reg();
      do_reset();
      inst_i = 32'h0002_1825;          // OR $3,$0,$2
      reg1_data_i = 32'h0;
      fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd0}; fwd_wdata_i = {32'h0, 32'hFFFF};
      tick();
      vectors++; if (ex_reg1_o !== 32'h0) begin miscompares++; $display("FAIL zero_reg got %h exp 0", ex_reg1_o); end
   endtask

   task automatic test_load_use();
      do_reset();
      inst_i = 32'h3401_1100;          // put a live instruction into EX first
      tick();
      inst_i = 32'h0084_2821;          // ADDU $5,$4,$4
      ex_is_load_i = 1; fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd4};
      #1;
      vectors++; if (stallreq_o !== 1'b1 || branch_flag_o !== 1'b0) begin miscompares++; $display("FAIL lu_stall got %0b/%0b exp 1/0", stallreq_o, branch_flag_o); end
      inst_i = 32'h1084_0001;          // BEQ $4,$4,+1: would be taken
      #1;
      vectors++; if (stallreq_o !== 1'b1 || branch_flag_o !== 1'b0) begin miscompares++; $display("FAIL lu_branch got %0b/%0b exp 1/0", stallreq_o, branch_flag_o); end
      ex_is_load_i = 0;
      #1;
      vectors++; if (stallreq_o !== 1'b0 || branch_flag_o !== 1'b1) begin miscompares++; $display("FAIL lu_noload got %0b/%0b exp 0/1", stallreq_o, branch_flag_o); end
      ex_is_load_i = 1; inst_i = 32'h0084_2821;
      stall_id_i = 1; stall_ex_i = 0;
      tick();
      vectors++; if (ex_wreg_o !== 1'b0 || ex_aluop_o !== 8'h00) begin miscompares++; $display("FAIL lu_bubble got %0b/%h exp 0/00", ex_wreg_o, ex_aluop_o); end
   endtask

   task automatic test_hold();
      do_reset();
      inst_i = 32'h3401_1100;
      tick();
      inst_i = 32'h0022_1825; stall_id_i = 1; stall_ex_i = 1;
      tick();
      vectors++; if (ex_reg2_o !== 32'h1100 || ex_wd_o !== 5'd1 || ex_wreg_o !== 1'b1) begin miscompares++; $display("FAIL hold got %h/%0d/%0b exp 00001100/1/1", ex_reg2_o, ex_wd_o, ex_wreg_o); end
      flush_i = 1;
      tick();
      vectors++; if (ex_wreg_o !== 1'b0 || ex_reg2_o !== 32'h0) begin miscompares++; $display("FAIL flush_stall got %0b/%h exp 0/0", ex_wreg_o, ex_reg2_o); end
   endtask

   task automatic test_branch_ds();
      do_reset();
      pc_i = 32'h100; inst_i = 32'h1021_0003;   // BEQ $1,$1,+3
      reg1_data_i = 7; reg2_data_i = 7;
      #1;
      vectors++; if (branch_flag_o !== 1'b1 || branch_target_o !== 32'h110) begin miscompares++; $display("FAIL beq got %0b/%h exp 1/00000110", branch_flag_o, branch_target_o); end
      tick();
      vectors++; if (in_delayslot_o !== 1'b1 || ex_in_delayslot_o !== 1'b0) begin miscompares++; $display("FAIL ds1 got %0b/%0b exp 1/0", in_delayslot_o, ex_in_delayslot_o); end
      pc_i = 32'h104; inst_i = 32'h0;
      tick();
      vectors++; if (ex_in_delayslot_o !== 1'b1 || in_delayslot_o !== 1'b0) begin miscompares++; $display("FAIL ds2 got %0b/%0b exp 1/0", ex_in_delayslot_o, in_delayslot_o); end
      inst_i = 32'h1422_0003;                   // BNE $1,$2 with equal data
      reg1_data_i = 5; reg2_data_i = 5;
      #1;
      vectors++; if (branch_flag_o !== 1'b0) begin miscompares++; $display("FAIL bne got %0b exp 0", branch_flag_o); end
   endtask

   task automatic test_jump();
      do_reset();
      pc_i = 32'h200; inst_i = 32'h0C00_0010;   // JAL 0x40
      flush_i = 1;
      #1;
      vectors++; if (branch_flag_o !== 1'b1 || branch_target_o !== 32'h40) begin miscompares++; $display("FAIL jal_tgt got %0b/%h exp 1/00000040", branch_flag_o, branch_target_o); end
      tick();
      vectors++; if (ex_wreg_o !== 1'b0 || ex_wd_o !== 5'd0 || ex_link_addr_o !== 32'h0 || in_delayslot_o !== 1'b0) begin miscompares++; $display("FAIL jal_flush got %0b/%0d/%h/%0b exp 0/0/0/0", ex_wreg_o, ex_wd_o, ex_link_addr_o, in_delayslot_o); end
      flush_i = 0;
      tick();
      vectors++; if (ex_wd_o !== 5'd31 || ex_link_addr_o !== 32'h208 || ex_wreg_o !== 1'b1) begin miscompares++; $display("FAIL jal got %0d/%h/%0b exp 31/00000208/1", ex_wd_o, ex_link_addr_o, ex_wreg_o); end
      vectors++; if (in_delayslot_o !== 1'b1) begin miscompares++; $display("FAIL jal_ds got %0b exp 1", in_delayslot_o); end
      inst_i = 32'h03E0_0008; reg1_data_i = 32'h300;   // JR $31
      #1;
      vectors++; if (branch_flag_o !== 1'b1 || branch_target_o !== 32'h300) begin miscompares++; $display("FAIL jr got %0b/%h exp 1/00000300", branch_flag_o, branch_target_o); end
   endtask

   task automatic test_movn();
      do_reset();
      inst_i = 32'h00E8_300B;          // MOVN $6,$7,$8
      reg2_data_i = 5;
      fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd8}; fwd_wdata_i = {32'h0, 32'h0};
      tick();
      vectors++; if (ex_wreg_o !== 1'b0 || ex_wd_o !== 5'd6) begin miscompares++; $display("FAIL movn_zero got %0b/%0d exp 0/6", ex_wreg_o, ex_wd_o); end
      fwd_wdata_i = {32'h0, 32'h9};
      tick();
      vectors++; if (ex_wreg_o !== 1'b1) begin miscompares++; $display("FAIL movn_nz got %0b exp 1", ex_wreg_o); end
   endtask

   initial begin
      set_idle();
      rst = 1;
      test_reset();
      test_ori();
      test_fwd_priority();
      test_zero_reg();
      test_load_use();
      test_hold();
      test_branch_ds();
      test_jump();
      test_movn();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
